alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_defs_pkg.sv | 34 +++
 rtl/alu_decode.sv | 37 +++
 rtl/alu_exec_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_defs_pkg.sv
// Shared encodings for the ALU execution unit: result codes, R-type funct
// values, alu_op selectors and FSM state encoding.
package alu_defs_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_MULTU = 4'b1010;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_ILL   = 4'b1111;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_MULTU = 6'b011001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational alu_op/funct decode. Anything not decodable (including MULTU
// when the multiplier is disabled) falls through to ALU_ILL.
module alu_decode
  import alu_defs_pkg::*;
#(
  parameter int MULT_EN = 1
) (
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_code,
  output logic       illegal
);

  always_comb begin
    alu_code = ALU_ILL;
    case (alu_op)
      ALUOP_ADD: alu_code = ALU_ADD;
      ALUOP_SUB: alu_code = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD:   alu_code = ALU_ADD;
          FN_SUB:   alu_code = ALU_SUB;
          FN_AND:   alu_code = ALU_AND;
          FN_OR:    alu_code = ALU_OR;
          FN_NOR:   alu_code = ALU_NOR;
          FN_SLT:   alu_code = ALU_SLT;
          FN_SLTU:  alu_code = ALU_SLTU;
          FN_MULTU: if (MULT_EN != 0) alu_code = ALU_MULTU;
          default:  ;
        endcase
      end
      default: ;
    endcase
    illegal = (alu_code == ALU_ILL);
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle ALU ops plus an optional WIDTH-cycle
// shift-add unsigned multiply, with a valid/ready handshake on both sides.
module alu_exec_unit
  import alu_defs_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MULT_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       alu_code,
  output logic             zero,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH);

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   mcand, acc, acc_nxt;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     alu_res;
  logic [3:0]           dec_code;
  logic                 dec_ill;
  logic                 accept, is_mul, mul_last;

  alu_decode #(.MULT_EN(MULT_EN)) u_dec (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_code (dec_code),
    .illegal  (dec_ill)
  );

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (dec_code == ALU_MULTU);
  assign mul_last = (state == ST_MUL) && (cnt == CW'(WIDTH - 1));
  assign acc_nxt  = mplier[0] ? acc + mcand : acc;

  always_comb begin
    alu_res = '0;
    case (dec_code)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_NOR:  alu_res = ~(op_a | op_b);
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && is_mul) state_nxt = ST_MUL;
      ST_MUL:  if (mul_last)         state_nxt = ST_DONE;
      ST_DONE: if (out_ready)        state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      alu_code  <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && is_mul) begin
            mcand     <= {{WIDTH{1'b0}}, op_a};
            mplier    <= op_b;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
          end else if (accept) begin
            // new result overwrites any result consumed on this same edge
            out_valid <= 1'b1;
            result    <= alu_res;
            result_hi <= '0;
            alu_code  <= dec_code;
            zero      <= (alu_res == '0);
            illegal   <= dec_ill;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        ST_MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (mul_last) begin
            out_valid <= 1'b1;
            result    <= acc_nxt[WIDTH-1:0];
            result_hi <= acc_nxt[2*WIDTH-1:WIDTH];
            alu_code  <= ALU_MULTU;
            zero      <= (acc_nxt[WIDTH-1:0] == '0);
            illegal   <= 1'b0;
          end
        end
        ST_DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
